// File: rtl/encoder_8to3_if.sv
// Bus bundle for encoder_8to3: capture enable, request vector and registered results.
// The err signal exists only when ENCODER_8TO3_ERR_EN is defined.
interface encoder_8to3_if;
  logic       en;
  logic [7:0] y;
  logic [2:0] a;
  logic       valid;
`ifdef ENCODER_8TO3_ERR_EN
  logic       err;
`endif

`ifdef ENCODER_8TO3_ERR_EN
  modport master (output en, output y, input a, input valid, input err);
  modport slave  (input en, input y, output a, output valid, output err);
`else
  modport master (output en, output y, input a, input valid);
  modport slave  (input en, input y, output a, output valid);
`endif
endinterface

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder (highest set bit wins), one clock latency.
// Optional multi-hot error flag enabled by defining ENCODER_8TO3_ERR_EN.
module encoder_8to3 (
  input  logic            clk,
  input  logic            rst,
  encoder_8to3_if.slave   bus
);

  logic [2:0] idx;
  logic [2:0] a_d, a_q;
  logic       valid_d, valid_q;

  // Ascending scan so the last match, i.e. the highest set bit, is kept.
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.y[i]) idx = 3'(i);
    end
  end

  always_comb begin
    a_d     = a_q;
    valid_d = valid_q;
    if (bus.en) begin
      a_d     = idx;
      valid_d = (bus.y != 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      valid_q <= valid_d;
    end
  end

  assign bus.a     = a_q;
  assign bus.valid = valid_q;

`ifdef ENCODER_8TO3_ERR_EN
  logic err_d, err_q;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  always_comb begin
    err_d = err_q;
    if (bus.en) err_d = ((bus.y & (bus.y - 8'd1)) != 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_encoder_8to3.sv
// Directed self-checking bench for encoder_8to3; also checks err when ENCODER_8TO3_ERR_EN is defined.
module tb_encoder_8to3;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  encoder_8to3_if bus ();

  encoder_8to3 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] exp_a, input logic exp_v, input logic exp_e);
    checks++;
    assert (bus.a === exp_a) else begin
      errors++;
      $error("FAIL %s a: got %0d expected %0d", tag, bus.a, exp_a);
    end
    checks++;
    assert (bus.valid === exp_v) else begin
      errors++;
      $error("FAIL %s valid: got %0b expected %0b", tag, bus.valid, exp_v);
    end
`ifdef ENCODER_8TO3_ERR_EN
    checks++;
    assert (bus.err === exp_e) else begin
      errors++;
      $error("FAIL %s err: got %0b expected %0b", tag, bus.err, exp_e);
    end
`else
    if (exp_e) begin end
`endif
    $display("%s: y=%h en=%0b rst=%0b -> a=%0d valid=%0b", tag, bus.y, bus.en, rst, bus.a, bus.valid);
  endtask

  initial begin
    logic [7:0] walk [8];
    for (int i = 0; i < 8; i++) walk[i] = 8'h01 << i;

    // Reset dominates en with all inputs high
    rst = 1'b1; bus.en = 1'b1; bus.y = 8'hFF;
    tick(); check("reset1", 3'd0, 1'b0, 1'b0);
    tick(); check("reset2", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // One-hot walk
    for (int i = 0; i < 8; i++) begin
      bus.y = walk[i];
      tick(); check($sformatf("walk%0d", i), 3'(i), 1'b1, 1'b0);
    end

    // Zero and priority
    bus.y = 8'h00; tick(); check("zero",  3'd0, 1'b0, 1'b0);
    bus.y = 8'h81; tick(); check("y81",   3'd7, 1'b1, 1'b1);
    bus.y = 8'h06; tick(); check("y06",   3'd2, 1'b1, 1'b1);
    bus.y = 8'hFF; tick(); check("yFF",   3'd7, 1'b1, 1'b1);
    bus.y = 8'h30; tick(); check("y30",   3'd5, 1'b1, 1'b1);

    // Enable hold
    bus.y = 8'h10; tick(); check("pre_hold", 3'd4, 1'b1, 1'b0);
    bus.en = 1'b0; bus.y = 8'h02;
    tick(); check("hold1", 3'd4, 1'b1, 1'b0);
    tick(); check("hold2", 3'd4, 1'b1, 1'b0);
    tick(); check("hold3", 3'd4, 1'b1, 1'b0);
    bus.en = 1'b1; tick(); check("resume", 3'd1, 1'b1, 1'b0);

    // Hold of an err=1 state with zero input presented
    bus.y = 8'h03; tick(); check("y03", 3'd1, 1'b1, 1'b1);
    bus.en = 1'b0; bus.y = 8'h00; tick(); check("hold_err", 3'd1, 1'b1, 1'b1);
    bus.en = 1'b1;

    // Mid-stream reset
    bus.y = 8'h20; tick(); check("pre_rst", 3'd5, 1'b1, 1'b0);
    rst = 1'b1; bus.y = 8'h80; tick(); check("mid_rst", 3'd0, 1'b0, 1'b0);
    rst = 1'b0; tick(); check("post_rst", 3'd7, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
